// File: rtl/data_mem_dump_arbiter_if.sv
// +--------------------------------------------------------------------------+
// | data_mem_dump_arbiter_if                                                 |
// | Pipeline, memory-port and dump-stream signals of the data-memory arbiter.|
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
`default_nettype none

interface data_mem_dump_arbiter_if #(
   parameter int LEN         = 32,
   parameter int NB_ADDR_MEM = 11
);
   logic [LEN-1:0]         i_pipe_addr;
   logic [LEN-1:0]         i_pipe_wdata;
   logic                   i_pipe_mem_read;
   logic                   i_pipe_mem_write;
   logic [LEN-1:0]         o_pipe_rdata;
   logic                   i_halted;
   logic                   i_dump_start;
   logic [NB_ADDR_MEM-1:0] o_mem_addr;
   logic [LEN-1:0]         o_mem_wdata;
   logic                   o_mem_wea;
   logic                   o_mem_ena;
   logic [LEN-1:0]         i_mem_rdata;
   logic [LEN-1:0]         o_dump_data;
   logic                   o_dump_valid;
   logic                   i_dump_ready;
   logic                   o_dump_busy;
   logic                   o_dump_done;
   logic                   o_dump_abort;

   // Arbiter side.
   modport slave (
      input  i_pipe_addr, i_pipe_wdata, i_pipe_mem_read, i_pipe_mem_write,
      input  i_halted, i_dump_start, i_mem_rdata, i_dump_ready,
      output o_pipe_rdata, o_mem_addr, o_mem_wdata, o_mem_wea, o_mem_ena,
      output o_dump_data, o_dump_valid, o_dump_busy, o_dump_done, o_dump_abort
   );

   // Environment side: pipeline, memory and debug unit.
   modport master (
      output i_pipe_addr, i_pipe_wdata, i_pipe_mem_read, i_pipe_mem_write,
      output i_halted, i_dump_start, i_mem_rdata, i_dump_ready,
      input  o_pipe_rdata, o_mem_addr, o_mem_wdata, o_mem_wea, o_mem_ena,
      input  o_dump_data, o_dump_valid, o_dump_busy, o_dump_done, o_dump_abort
   );
endinterface

`default_nettype wire

// File: rtl/data_mem_dump_arbiter.sv
// +--------------------------------------------------------------------------+
// | data_mem_dump_arbiter                                                    |
// | Shares the MEM-stage data memory port between the pipeline and a debug   |
// | dump sequencer. Define DUMP_ADDR_TAG_EN to send address/data pairs.      |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
`default_nettype none

module data_mem_dump_arbiter #(
   parameter int LEN         = 32,
   parameter int NB_ADDR_MEM = 11,
   parameter int DUMP_WORDS  = 2048
) (
   input  logic                     i_clk,
   input  logic                     i_rst,
   data_mem_dump_arbiter_if.slave   bus
);

   localparam logic [NB_ADDR_MEM-1:0] LAST_ADDR = NB_ADDR_MEM'(DUMP_WORDS - 1);

   typedef enum logic [2:0] {
      ST_IDLE      = 3'd0,
      ST_WAIT_HALT = 3'd1,
      ST_ISSUE     = 3'd2,
      ST_CAPTURE   = 3'd3,
      ST_SEND      = 3'd4,
      ST_DONE      = 3'd5
`ifdef DUMP_ADDR_TAG_EN
      ,ST_SEND_ADDR = 3'd6
`endif
   } state_t;

   state_t                 state_q;
   logic [NB_ADDR_MEM-1:0] cnt_q;
   logic [LEN-1:0]         dump_data_q;
   logic                   valid_q;
   logic                   busy_q;
   logic                   done_q;
   logic                   abort_q;
`ifdef DUMP_ADDR_TAG_EN
   logic [LEN-1:0]         word_q;
`endif

   logic seq_owns;
   logic unused_pipe_addr_hi;

   assign seq_owns            = (state_q != ST_IDLE) && (state_q != ST_WAIT_HALT);
   assign unused_pipe_addr_hi = ^bus.i_pipe_addr[LEN-1:NB_ADDR_MEM];

   // Pipeline path is purely combinational so the MEM stage sees no extra latency.
   assign bus.o_mem_addr   = seq_owns ? cnt_q : bus.i_pipe_addr[NB_ADDR_MEM-1:0];
   assign bus.o_mem_wdata  = seq_owns ? '0 : bus.i_pipe_wdata;
   assign bus.o_mem_wea    = seq_owns ? 1'b0 : bus.i_pipe_mem_write;
   assign bus.o_mem_ena    = seq_owns ? (state_q == ST_ISSUE)
                                      : (bus.i_pipe_mem_read | bus.i_pipe_mem_write);
   assign bus.o_pipe_rdata = bus.i_mem_rdata;

   assign bus.o_dump_data  = dump_data_q;
   assign bus.o_dump_valid = valid_q;
   assign bus.o_dump_busy  = busy_q;
   assign bus.o_dump_done  = done_q;
   assign bus.o_dump_abort = abort_q;

   always_ff @(posedge i_clk or negedge i_rst) begin
      if (!i_rst) begin
         state_q     <= ST_IDLE;
         cnt_q       <= '0;
         dump_data_q <= '0;
         valid_q     <= 1'b0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         abort_q     <= 1'b0;
`ifdef DUMP_ADDR_TAG_EN
         word_q      <= '0;
`endif
      end else begin
         done_q  <= 1'b0;
         abort_q <= 1'b0;
         case (state_q)
            ST_IDLE: begin
               if (bus.i_dump_start) begin
                  state_q <= ST_WAIT_HALT;
                  cnt_q   <= '0;
                  busy_q  <= 1'b1;
               end
            end
            ST_WAIT_HALT: begin
               if (bus.i_halted) begin
                  state_q <= ST_ISSUE;
               end
            end
            ST_ISSUE: begin
               if (!bus.i_halted) begin
                  state_q <= ST_IDLE;
                  busy_q  <= 1'b0;
                  abort_q <= 1'b1;
               end else begin
                  state_q <= ST_CAPTURE;
               end
            end
            ST_CAPTURE: begin
               if (!bus.i_halted) begin
                  state_q <= ST_IDLE;
                  busy_q  <= 1'b0;
                  abort_q <= 1'b1;
               end else begin
                  valid_q <= 1'b1;
`ifdef DUMP_ADDR_TAG_EN
                  word_q      <= bus.i_mem_rdata;
                  dump_data_q <= LEN'(cnt_q);
                  state_q     <= ST_SEND_ADDR;
`else
                  dump_data_q <= bus.i_mem_rdata;
                  state_q     <= ST_SEND;
`endif
               end
            end
`ifdef DUMP_ADDR_TAG_EN
            ST_SEND_ADDR: begin
               if (!bus.i_halted) begin
                  state_q <= ST_IDLE;
                  valid_q <= 1'b0;
                  busy_q  <= 1'b0;
                  abort_q <= 1'b1;
               end else if (bus.i_dump_ready) begin
                  // Valid stays high: the data word follows the address tag back to back.
                  dump_data_q <= word_q;
                  state_q     <= ST_SEND;
               end
            end
`endif
            ST_SEND: begin
               if (!bus.i_halted) begin
                  state_q <= ST_IDLE;
                  valid_q <= 1'b0;
                  busy_q  <= 1'b0;
                  abort_q <= 1'b1;
               end else if (bus.i_dump_ready) begin
                  valid_q <= 1'b0;
                  if (cnt_q == LAST_ADDR) begin
                     state_q <= ST_DONE;
                     done_q  <= 1'b1;
                  end else begin
                     cnt_q   <= cnt_q + NB_ADDR_MEM'(1);
                     state_q <= ST_ISSUE;
                  end
               end
            end
            ST_DONE: begin
               state_q <= ST_IDLE;
               busy_q  <= 1'b0;
            end
            default: begin
               state_q <= ST_IDLE;
               valid_q <= 1'b0;
               busy_q  <= 1'b0;
            end
         endcase
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_data_mem_dump_arbiter.sv
// +--------------------------------------------------------------------------+
// | tb_data_mem_dump_arbiter                                                 |
// | Scoreboard bench for data_mem_dump_arbiter with a synchronous RAM model. |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
`default_nettype none

module tb_data_mem_dump_arbiter;

   localparam int LEN         = 32;
   localparam int NB_ADDR_MEM = 11;
   localparam int DUMP_WORDS  = 4;
`ifdef DUMP_ADDR_TAG_EN
   localparam int          CYC_PER_WORD = 4;
   localparam logic [31:0] HOLD_EXP     = 32'd2;
`else
   localparam int          CYC_PER_WORD = 3;
   localparam logic [31:0] HOLD_EXP     = 32'h102;
`endif

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   data_mem_dump_arbiter_if #(.LEN(LEN), .NB_ADDR_MEM(NB_ADDR_MEM)) bus ();

   data_mem_dump_arbiter #(
      .LEN(LEN), .NB_ADDR_MEM(NB_ADDR_MEM), .DUMP_WORDS(DUMP_WORDS)
   ) dut (
      .i_clk(clk),
      .i_rst(rst_n),
      .bus  (bus)
   );

   logic [LEN-1:0] mem [0:(1<<NB_ADDR_MEM)-1];
   logic [LEN-1:0] rdata_q;

   initial begin
      rdata_q <= '0;
      for (int i = 0; i < (1 << NB_ADDR_MEM); i++)
         mem[i] <= (i < DUMP_WORDS) ? (32'h100 + 32'(i)) : 32'h0;
   end

   always @(posedge clk) begin
      if (bus.o_mem_ena) begin
         if (bus.o_mem_wea) mem[bus.o_mem_addr] <= bus.o_mem_wdata;
         rdata_q <= mem[bus.o_mem_addr];
      end
   end
   assign bus.i_mem_rdata = rdata_q;

   int          n_cmp = 0;
   int          n_bad = 0;
   int          done_cnt = 0;
   int          abort_cnt = 0;
   logic [31:0] sb [$];

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%08h, want 0x%08h", tag, act, exp);
      end
   endtask

   task automatic tick();
      @(negedge clk);
      #1;
   endtask

   task automatic push_dump(input int nwords);
      for (int i = 0; i < nwords; i++) begin
`ifdef DUMP_ADDR_TAG_EN
         sb.push_back(32'(i));
`endif
         sb.push_back(32'h100 + 32'(i));
      end
   endtask

   task automatic pulse_start();
      tick(); bus.i_dump_start = 1'b1;
      tick(); bus.i_dump_start = 1'b0;
      #1;
   endtask

   task automatic wait_issue(input logic [NB_ADDR_MEM-1:0] a, input int max,
                             output int n, output logic ok);
      n  = 0;
      ok = 1'b0;
      while (!ok && n < max) begin
         tick(); #1;
         n++;
         ok = bus.o_mem_ena && bus.o_dump_busy && (bus.o_mem_addr == a);
      end
   endtask

   task automatic wait_valid(input int max);
      for (int i = 0; i < max && !bus.o_dump_valid; i++) begin
         tick(); #1;
      end
   endtask

   task automatic wait_done(input int max, output int n);
      n = 0;
      while (!bus.o_dump_done && n < max) begin
         tick(); #1;
         n++;
      end
   endtask

   // Scoreboard: every accepted dump transfer pops one expected word.
   initial begin
      logic [31:0] exp_w;
      forever begin
         @(negedge clk);
         #3;
         if (rst_n && bus.o_dump_valid && bus.i_dump_ready) begin
            if (sb.size() == 0) begin
               chk("sb_pop_empty", 32'(sb.size()), 32'd1);
            end else begin
               exp_w = sb.pop_front();
               chk("dump_word", bus.o_dump_data, exp_w);
            end
         end
         if (bus.o_dump_abort) abort_cnt++;
         if (bus.o_dump_done)  done_cnt++;
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout, want completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int   n, cyc, d0, a0, hold_bad, ena_cnt, wea_cnt;
      logic ok;

      bus.i_pipe_addr      = '0;
      bus.i_pipe_wdata     = '0;
      bus.i_pipe_mem_read  = 1'b0;
      bus.i_pipe_mem_write = 1'b0;
      bus.i_halted         = 1'b0;
      bus.i_dump_start     = 1'b0;
      bus.i_dump_ready     = 1'b0;

      tick(); tick(); #1;
      chk("rst_busy",  32'(bus.o_dump_busy), 32'd0);
      chk("rst_valid", 32'(bus.o_dump_valid), 32'd0);
      chk("rst_data",  bus.o_dump_data, 32'd0);
      chk("rst_pulse", 32'({bus.o_dump_done, bus.o_dump_abort}), 32'd0);
      chk("rst_ena",   32'(bus.o_mem_ena), 32'd0);
      rst_n = 1'b1;

      // Pass-through write then read; upper address bits are dropped.
      tick();
      bus.i_pipe_addr = 32'h0001_0005; bus.i_pipe_wdata = 32'hDEADBEEF;
      bus.i_pipe_mem_write = 1'b1;
      #1;
      chk("pt_wr_wea",   32'(bus.o_mem_wea), 32'd1);
      chk("pt_wr_ena",   32'(bus.o_mem_ena), 32'd1);
      chk("pt_wr_addr",  32'(bus.o_mem_addr), 32'd5);
      chk("pt_wr_wdata", bus.o_mem_wdata, 32'hDEADBEEF);
      tick();
      bus.i_pipe_mem_write = 1'b0; bus.i_pipe_mem_read = 1'b1; bus.i_pipe_wdata = '0;
      #1;
      chk("pt_rd_wea", 32'(bus.o_mem_wea), 32'd0);
      chk("pt_rd_ena", 32'(bus.o_mem_ena), 32'd1);
      tick();
      bus.i_pipe_mem_read = 1'b0; bus.i_pipe_addr = '0;
      #1;
      chk("pt_rdata", bus.o_pipe_rdata, 32'hDEADBEEF);

      // Full dump, already halted, ready tied high; pipeline writes must be dropped.
      bus.i_halted = 1'b1; bus.i_dump_ready = 1'b1;
      push_dump(DUMP_WORDS);
      d0 = done_cnt; a0 = abort_cnt;
      pulse_start();
      chk("t2_busy_wait", 32'(bus.o_dump_busy), 32'd1);
      wait_issue('0, 10, n, ok);
      chk("t2_issue_lat", 32'(n), 32'd1);
      bus.i_pipe_addr = 32'd2; bus.i_pipe_wdata = 32'hBAD; bus.i_pipe_mem_write = 1'b1;
      cyc = 1; wea_cnt = 0;
      while (!bus.o_dump_done && cyc < 200) begin
         tick(); #1;
         cyc++;
         wea_cnt += 32'(bus.o_mem_wea);
      end
      bus.i_pipe_mem_write = 1'b0; bus.i_pipe_addr = '0; bus.i_pipe_wdata = '0;
      chk("t2_cycles",      32'(cyc), 32'(CYC_PER_WORD * DUMP_WORDS + 1));
      chk("t2_wea_blocked", 32'(wea_cnt), 32'd0);
      chk("t2_busy_done",   32'(bus.o_dump_busy), 32'd1);
      tick(); #1;
      chk("t2_idle_busy", 32'(bus.o_dump_busy), 32'd0);
      chk("t2_done_once", 32'(done_cnt - d0), 32'd1);
      chk("t2_no_abort",  32'(abort_cnt - a0), 32'd0);
      chk("t2_sb_empty",  32'(sb.size()), 32'd0);

      // Backpressure on word 2, with a stray start pulse during the hold.
      push_dump(DUMP_WORDS);
      pulse_start();
      wait_issue(NB_ADDR_MEM'(2), 40, n, ok);
      chk("t3_issue2", 32'(ok), 32'd1);
      bus.i_dump_ready = 1'b0;
      wait_valid(10);
      hold_bad = 0; ena_cnt = 0;
      for (int i = 0; i < 10; i++) begin
         tick();
         bus.i_dump_start = (i == 4);
         #1;
         if (!bus.o_dump_valid || bus.o_dump_data !== HOLD_EXP) hold_bad++;
         ena_cnt += 32'(bus.o_mem_ena);
      end
      bus.i_dump_start = 1'b0;
      chk("t3_hold_bad",   32'(hold_bad), 32'd0);
      chk("t3_hold_reads", 32'(ena_cnt), 32'd0);
      chk("t3_hold_data",  bus.o_dump_data, HOLD_EXP);
      bus.i_dump_ready = 1'b1;
      wait_done(100, n);
      chk("t3_done", 32'(bus.o_dump_done), 32'd1);
      tick(); #1;
      chk("t3_sb_empty", 32'(sb.size()), 32'd0);

      // Deferred start: pipeline still served while waiting for the halt.
      bus.i_halted = 1'b0;
      push_dump(DUMP_WORDS);
      pulse_start();
      for (int i = 0; i < 20; i++) begin
         tick();
         bus.i_pipe_addr      = (i == 5 || i == 6) ? 32'd9 : 32'd0;
         bus.i_pipe_wdata     = (i == 5) ? 32'hCAFE0009 : 32'd0;
         bus.i_pipe_mem_write = (i == 5);
         bus.i_pipe_mem_read  = (i == 6);
         #1;
         if (i == 0) chk("t4_busy_wait", 32'(bus.o_dump_busy), 32'd1);
         if (i == 5) chk("t4_wr_pass", 32'({bus.o_mem_wea, bus.o_mem_ena}), 32'd3);
         if (i == 7) chk("t4_rdata", bus.o_pipe_rdata, 32'hCAFE0009);
      end
      tick(); bus.i_halted = 1'b1; #1;
      chk("t4_no_issue_yet", 32'(bus.o_mem_ena), 32'd0);
      tick(); #1;
      chk("t4_issue_ena",  32'(bus.o_mem_ena), 32'd1);
      chk("t4_issue_addr", 32'(bus.o_mem_addr), 32'd0);
      wait_done(100, n);
      chk("t4_done", 32'(bus.o_dump_done), 32'd1);
      tick(); #1;
      chk("t4_sb_empty", 32'(sb.size()), 32'd0);

      // Abort while word 1 is pending, then restart from word 0.
      push_dump(1);
      pulse_start();
      wait_issue(NB_ADDR_MEM'(1), 20, n, ok);
      chk("t5_issue1", 32'(ok), 32'd1);
      bus.i_dump_ready = 1'b0;
      wait_valid(10);
      d0 = done_cnt; a0 = abort_cnt;
      tick(); bus.i_halted = 1'b0; #1;
      chk("t5_valid_pending", 32'(bus.o_dump_valid), 32'd1);
      tick(); #1;
      chk("t5_abort",      32'(bus.o_dump_abort), 32'd1);
      chk("t5_valid_drop", 32'(bus.o_dump_valid), 32'd0);
      chk("t5_idle",       32'(bus.o_dump_busy), 32'd0);
      tick(); #1;
      chk("t5_abort_once", 32'(abort_cnt - a0), 32'd1);
      chk("t5_no_done",    32'(done_cnt - d0), 32'd0);
      chk("t5_sb_empty",   32'(sb.size()), 32'd0);
      bus.i_halted = 1'b1; bus.i_dump_ready = 1'b1;
      push_dump(DUMP_WORDS);
      pulse_start();
      wait_issue('0, 5, n, ok);
      chk("t5_restart_w0", 32'(ok), 32'd1);
      wait_done(100, n);
      chk("t5_restart_done", 32'(bus.o_dump_done), 32'd1);
      tick(); #1;
      chk("t5_sb_empty2", 32'(sb.size()), 32'd0);

      // Asynchronous reset in the middle of a send.
      bus.i_dump_ready = 1'b0;
      pulse_start();
      wait_valid(10);
      d0 = done_cnt; a0 = abort_cnt;
      tick(); rst_n = 1'b0; #1;
      chk("t6_rst_busy",  32'(bus.o_dump_busy), 32'd0);
      chk("t6_rst_valid", 32'(bus.o_dump_valid), 32'd0);
      tick(); rst_n = 1'b1;
      tick(); #1;
      chk("t6_no_pulse", 32'((done_cnt - d0) + (abort_cnt - a0)), 32'd0);
      chk("t6_idle",     32'(bus.o_dump_busy), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/data_mem_dump_arbiter.md
Name: data_mem_dump_arbiter

Overview:
Owns the single port of the MEM-stage data memory and shares it between the pipeline and the debug unit. Normal operation passes pipeline accesses straight through. On a dump request, and only once the pipeline is halted, a sequencer walks the memory from word 0 to DUMP_WORDS-1. Each word is handed to the debug UART path over a valid/ready handshake.

Parameters:
LEN, 32, data and pipeline address width
NB_ADDR_MEM, 11, memory word-address width (2048 words)
DUMP_WORDS, 2048, number of words dumped; 1 <= DUMP_WORDS <= 2^NB_ADDR_MEM

Ports:
i_clk  in  1  clock; all state changes on rising edge
i_rst  in  1  asynchronous active-low reset
i_pipe_addr  in  LEN  MEM-stage ALU result (address)
i_pipe_wdata  in  LEN  MEM-stage store data
i_pipe_mem_read  in  1  MemRead control
i_pipe_mem_write  in  1  MemWrite control
o_pipe_rdata  out  LEN  read data to MEM/WB
i_halted  in  1  pipeline halted (level)
i_dump_start  in  1  one-cycle dump request
o_mem_addr  out  NB_ADDR_MEM  memory address
o_mem_wdata  out  LEN  memory write data
o_mem_wea  out  1  memory write enable
o_mem_ena  out  1  memory enable
i_mem_rdata  in  LEN  memory read data, valid 1 cycle after ena
o_dump_data  out  LEN  word to debug unit
o_dump_valid  out  1  dump word valid
i_dump_ready  in  1  debug unit accepts word
o_dump_busy  out  1  high in any state except IDLE
o_dump_done  out  1  one-cycle pulse, dump complete
o_dump_abort  out  1  one-cycle pulse, dump aborted

Behaviour:
- Reset (i_rst=0, async): state IDLE; word counter 0; all outputs 0.
- Mux: in IDLE or WAIT_HALT, o_mem_addr = i_pipe_addr[NB_ADDR_MEM-1:0], o_mem_wdata = i_pipe_wdata, o_mem_wea = i_pipe_mem_write, o_mem_ena = i_pipe_mem_read | i_pipe_mem_write. Combinational, zero added latency.
- In every other state the sequencer drives the memory. o_mem_wea is held 0, and pipeline requests are dropped with no side effects.
- o_pipe_rdata = i_mem_rdata at all times.
- FSM:
  - IDLE: i_dump_start -> WAIT_HALT; counter cleared to 0.
  - WAIT_HALT: i_halted=1 -> ISSUE. If the pipeline is already halted at start, ISSUE is entered on the next cycle.
  - ISSUE: o_mem_ena=1, o_mem_addr=counter, for one cycle -> CAPTURE.
  - CAPTURE: o_dump_data <= i_mem_rdata (registered) -> SEND.
  - SEND: o_dump_valid=1; o_dump_data held stable until i_dump_ready=1.
    - On handshake with counter == DUMP_WORDS-1 -> DONE.
    - Otherwise counter+1 -> ISSUE.
  - DONE: o_dump_done=1 for one cycle -> IDLE.
- Per-word latency: 3 cycles plus the ready wait. Minimum full dump is 3*DUMP_WORDS+1 cycles from the first ISSUE.
- o_dump_valid is never withdrawn before its handshake, except on abort.
- i_dump_start while busy: ignored.
- i_halted falling in ISSUE, CAPTURE or SEND: next cycle goes to IDLE with o_dump_abort=1 for one cycle. o_dump_valid drops, o_dump_done is not asserted, and the pending word is discarded.
- i_halted falling in WAIT_HALT: no abort; keep waiting.
- Counter is NB_ADDR_MEM bits and never wraps; the DUMP_WORDS-1 check ends the walk.
- Reset mid-dump returns to IDLE immediately with no done or abort pulse.

Optional Feature:
Macro DUMP_ADDR_TAG_EN.
- Defined: state SEND_ADDR is inserted between CAPTURE and SEND. SEND_ADDR presents {(LEN-NB_ADDR_MEM) zeros, counter} with o_dump_valid=1 and waits for its own handshake. The debug unit therefore receives address/data pairs, 2*DUMP_WORDS transfers in total. Abort rules apply to SEND_ADDR the same as to SEND.
- Undefined: data words only, no SEND_ADDR state.

Test Plan:
1. Pass-through: IDLE, pipe write addr 5 data 0xDEADBEEF, then read addr 5 -> o_mem_wea=1 on the write cycle; o_pipe_rdata=0xDEADBEEF one cycle after the read.
2. Full dump: DUMP_WORDS=4, mem[i]=0x100+i, i_halted=1, i_dump_ready=1 tied -> o_dump_data 0x100..0x103, one word per 3 cycles, o_dump_done pulse 13 cycles after the first ISSUE, o_dump_busy then 0.
3. Backpressure: hold i_dump_ready=0 for 10 cycles on word 2 -> o_dump_valid stays 1 and o_dump_data stays 0x102; no extra memory reads during the hold.
4. Deferred start: pulse i_dump_start with i_halted=0, raise i_halted 20 cycles later -> pipeline accesses are still honoured in WAIT_HALT, and the first ISSUE follows one cycle after the halt.
5. Abort: drop i_halted during SEND of word 1 -> o_dump_abort pulses once, no o_dump_done, IDLE on the next cycle; a new i_dump_start restarts at word 0.
6. With DUMP_ADDR_TAG_EN, DUMP_WORDS=2 -> transfer sequence is 0, 0x100, 1, 0x101, then o_dump_done.
